pipe_reg_ctrl: RTL

- Sequencing controller for the femtoRV32 pipeline register banks: PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Generates per-bank load enables and bubble/flush strobes.
- Time-multiplexes the single-ported unified memory between instruction fetch and data access using a phase counter.
- Implements load-use stall, taken-branch flush, and halt/drain/resume sequencing. Sits beside the hazard unit in the core top level.

---
 rtl/pipe_reg_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/pipe_reg_ctrl.sv
// femtoRV32 pipeline-register sequencer: phase counter, bank loads/flushes, halt/drain.
// Optional perf counters (adv/stall/flush) when PIPE_PERF_CNT_EN is defined.
module pipe_reg_ctrl #(
  parameter int PHASES = 2,
  parameter int PW     = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_use,
  input  logic          branch_taken,
  input  logic          halt,
  input  logic          resume,
  output logic          pc_load,
  output logic          ifid_load,
  output logic          idex_load,
  output logic          exmem_load,
  output logic          memwb_load,
  output logic          ifid_flush,
  output logic          idex_flush,
  output logic          exmem_flush,
  output logic          mem_sel,
  output logic [PW-1:0] phase,
  output logic          halted
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]   adv_cnt,
  output logic [31:0]   stall_cnt,
  output logic [31:0]   flush_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HALTING = 2'd1,
    HALTED  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] ph;
  logic [1:0]    drain_cnt;
  logic [1:0]    drain_nxt;
  logic          adv;
  logic          do_idle;
  logic          do_br;
  logic          do_bub;
  logic          do_halt;

  assign adv = (ph == PW'(PHASES - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      ph        <= '0;
      state     <= RUN;
      drain_cnt <= '0;
    end else begin
      ph        <= adv ? '0 : ph + PW'(1);
      state     <= state_nxt;
      drain_cnt <= drain_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    drain_nxt = drain_cnt;
    if (adv) begin
      unique case (state)
        RUN: begin
          if (!branch_taken && !load_use && halt) begin
            state_nxt = HALTING;
            drain_nxt = '0;
          end
        end
        HALTING: begin
          if (branch_taken) begin
            state_nxt = RUN;
            drain_nxt = '0;
          end else begin
            drain_nxt = drain_cnt + 2'd1;
            if (drain_cnt == 2'd2)
              state_nxt = HALTED;
          end
        end
        HALTED: begin
          if (resume)
            state_nxt = RUN;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  // One-hot advance response; only one of these can be true at a time.
  assign do_idle = (state == HALTED);
  assign do_br   = !do_idle && branch_taken;
  assign do_bub  = !do_br && ((state == HALTING) ||
                   (state == RUN && load_use));
  assign do_halt = (state == RUN) && !branch_taken &&
                   !load_use && halt;

  always_comb begin
    pc_load     = 1'b0;
    ifid_load   = 1'b0;
    idex_load   = 1'b0;
    exmem_load  = 1'b0;
    memwb_load  = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    if (rst && adv) begin
      unique case (1'b1)
        do_idle: ;
        do_br: begin
          {pc_load, ifid_load, idex_load} = 3'b111;
          {exmem_load, memwb_load} = 2'b11;
          {ifid_flush, idex_flush, exmem_flush} = 3'b111;
        end
        do_bub: begin
          {idex_load, exmem_load, memwb_load} = 3'b111;
          idex_flush = 1'b1;
        end
        do_halt: begin
          {idex_load, exmem_load, memwb_load} = 3'b111;
        end
        default: begin
          {pc_load, ifid_load, idex_load} = 3'b111;
          {exmem_load, memwb_load} = 2'b11;
        end
      endcase
    end
  end

  assign mem_sel = rst && (ph == '0);
  assign phase   = rst ? ph : '0;
  assign halted  = rst && (state == HALTED);

`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      adv_cnt   <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (state == RUN && pc_load)
        adv_cnt <= adv_cnt + 32'd1;
      if (state == RUN && idex_flush && !ifid_flush)
        stall_cnt <= stall_cnt + 32'd1;
      if (ifid_flush)
        flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule
